// File: rtl/ysyx_24110015_axi_arbiter.sv
// ysyx_24110015_axi_arbiter
//   Arbitrates one IFU read master and one LSU read/write master onto a single
//   downstream AXI master port. One transaction is granted at a time; the
//   winner's channels are wired combinationally to m_*, everything else is
//   held at 0. After every completion the arbiter spends one cycle in IDLE.
//
// Parameters
//   LSU_FIRST   1: LSU wins a same-cycle contest with the IFU, 0: IFU wins.
// Optional feature
//   ARB_PERF_CNT_EN  when defined, adds 32-bit wrapping grant/wait counters;
//                    when undefined the perf_* outputs are constant 0.
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ifu_ar* / ifu_r*              IFU read address / read data channels
//   lsu_ar* / lsu_r*              LSU read address / read data channels
//   lsu_aw* / lsu_w* / lsu_b*     LSU write address / data / response channels
//   m_*                           downstream AXI master (mirror of the LSU side)
//   perf_ifu_cnt/lsu_cnt/wait_cnt performance counters
module ysyx_24110015_axi_arbiter #(
  parameter int unsigned LSU_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  // IFU read
  input  logic [31:0] ifu_araddr,
  input  logic [2:0]  ifu_arsize,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rvalid,
  output logic        ifu_rlast,
  input  logic        ifu_rready,
  // LSU read
  input  logic [31:0] lsu_araddr,
  input  logic [2:0]  lsu_arsize,
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rvalid,
  output logic        lsu_rlast,
  input  logic        lsu_rready,
  // LSU write
  input  logic [31:0] lsu_awaddr,
  input  logic [2:0]  lsu_awsize,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wvalid,
  input  logic        lsu_wlast,
  output logic        lsu_wready,
  output logic [1:0]  lsu_bresp,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  // downstream master
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arsize,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awsize,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  output logic        m_wlast,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  // performance counters
  output logic [31:0] perf_ifu_cnt,
  output logic [31:0] perf_lsu_cnt,
  output logic [31:0] perf_wait_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_e;

  localparam bit LsuWins = (LSU_FIRST != 0);

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   lsu_req;

  assign lsu_req = lsu_arvalid | lsu_awvalid;

  // Payload and response fields are wired straight through; only the
  // handshake signals below are gated by the grant.
  assign ifu_rdata = m_rdata;
  assign ifu_rresp = m_rresp;
  assign ifu_rlast = m_rlast;
  assign lsu_rdata = m_rdata;
  assign lsu_rresp = m_rresp;
  assign lsu_rlast = m_rlast;
  assign m_awaddr  = lsu_awaddr;
  assign m_awsize  = lsu_awsize;
  assign m_wdata   = lsu_wdata;
  assign m_wstrb   = lsu_wstrb;
  assign m_wlast   = lsu_wlast;
  assign lsu_bresp = m_bresp;

  // Grant state and per-grant handshake-done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state selection and channel routing for the granted requester.
  always_comb begin
    state_d     = state_q;
    ar_done_d   = ar_done_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    m_araddr    = 32'd0;
    m_arsize    = 3'd0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        // A pending LSU read beats a pending LSU write.
        if (lsu_req && (LsuWins || !ifu_arvalid)) begin
          state_d = lsu_arvalid ? LSU_RD : LSU_WR;
        end else if (ifu_arvalid) begin
          state_d = IFU_RD;
        end else begin
          state_d = IDLE;
        end
      end
      IFU_RD, LSU_RD: begin
        if (state_q == IFU_RD) begin
          m_araddr    = ifu_araddr;
          m_arsize    = ifu_arsize;
          m_arvalid   = ifu_arvalid & ~ar_done_q;
          ifu_arready = m_arready & ~ar_done_q;
          m_rready    = ifu_rready;
          ifu_rvalid  = m_rvalid;
        end else begin
          m_araddr    = lsu_araddr;
          m_arsize    = lsu_arsize;
          m_arvalid   = lsu_arvalid & ~ar_done_q;
          lsu_arready = m_arready & ~ar_done_q;
          m_rready    = lsu_rready;
          lsu_rvalid  = m_rvalid;
        end
        // Only one address beat per grant ever reaches the slave.
        if (m_arvalid && m_arready) begin
          ar_done_d = 1'b1;
        end else begin
          ar_done_d = ar_done_q;
        end
        if (m_rvalid && m_rready && m_rlast) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      LSU_WR: begin
        m_awvalid   = lsu_awvalid & ~aw_done_q;
        lsu_awready = m_awready & ~aw_done_q;
        m_wvalid    = lsu_wvalid & ~w_done_q;
        lsu_wready  = m_wready & ~w_done_q;
        m_bready    = lsu_bready;
        lsu_bvalid  = m_bvalid;
        if (m_awvalid && m_awready) begin
          aw_done_d = 1'b1;
        end else begin
          aw_done_d = aw_done_q;
        end
        if (m_wvalid && m_wready && lsu_wlast) begin
          w_done_d = 1'b1;
        end else begin
          w_done_d = w_done_q;
        end
        if (m_bvalid && m_bready) begin
          state_d = IDLE;
        end else begin
          state_d = LSU_WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_ifu_cnt_q, perf_ifu_cnt_d;
  logic [31:0] perf_lsu_cnt_q, perf_lsu_cnt_d;
  logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;
  logic        ifu_blocked, lsu_blocked;

  // A requester is waiting when it holds valid while the other one owns the port.
  always_comb begin
    ifu_blocked     = ifu_arvalid && (state_q == LSU_RD || state_q == LSU_WR);
    lsu_blocked     = lsu_req && (state_q == IFU_RD);
    perf_ifu_cnt_d  = perf_ifu_cnt_q;
    perf_lsu_cnt_d  = perf_lsu_cnt_q;
    perf_wait_cnt_d = perf_wait_cnt_q;
    if (state_q == IDLE && state_d == IFU_RD) begin
      perf_ifu_cnt_d = perf_ifu_cnt_q + 32'd1;
    end else begin
      perf_ifu_cnt_d = perf_ifu_cnt_q;
    end
    if (state_q == IDLE && (state_d == LSU_RD || state_d == LSU_WR)) begin
      perf_lsu_cnt_d = perf_lsu_cnt_q + 32'd1;
    end else begin
      perf_lsu_cnt_d = perf_lsu_cnt_q;
    end
    if (ifu_blocked || lsu_blocked) begin
      perf_wait_cnt_d = perf_wait_cnt_q + 32'd1;
    end else begin
      perf_wait_cnt_d = perf_wait_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ifu_cnt_q  <= 32'd0;
      perf_lsu_cnt_q  <= 32'd0;
      perf_wait_cnt_q <= 32'd0;
    end else begin
      perf_ifu_cnt_q  <= perf_ifu_cnt_d;
      perf_lsu_cnt_q  <= perf_lsu_cnt_d;
      perf_wait_cnt_q <= perf_wait_cnt_d;
    end
  end

  assign perf_ifu_cnt  = perf_ifu_cnt_q;
  assign perf_lsu_cnt  = perf_lsu_cnt_q;
  assign perf_wait_cnt = perf_wait_cnt_q;
`else
  assign perf_ifu_cnt  = 32'd0;
  assign perf_lsu_cnt  = 32'd0;
  assign perf_wait_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
module tb_ysyx_24110015_axi_arbiter;

  localparam int unsigned LSU_FIRST = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic [2:0]  ifu_arsize;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid, ifu_rlast, ifu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid, lsu_rlast, lsu_rready;
  logic [31:0] lsu_awaddr;
  logic [2:0]  lsu_awsize;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid, lsu_wlast, lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rlast, m_rready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awsize;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wlast, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [31:0] perf_ifu_cnt, perf_lsu_cnt, perf_wait_cnt;

  int checks = 0;
  int errors = 0;

  ysyx_24110015_axi_arbiter #(.LSU_FIRST(LSU_FIRST)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rvalid(ifu_rvalid), .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_awvalid(lsu_awvalid),
    .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .perf_ifu_cnt(perf_ifu_cnt), .perf_lsu_cnt(perf_lsu_cnt), .perf_wait_cnt(perf_wait_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_araddr = 32'h3000_0000; ifu_arsize = 3'd2; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    lsu_araddr = 32'h0f00_0004; lsu_arsize = 3'd2; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    lsu_awaddr = 32'h0f00_0008; lsu_awsize = 3'd2; lsu_awvalid = 1'b0;
    lsu_wdata = 32'hdead_beef; lsu_wstrb = 4'hf; lsu_wvalid = 1'b0; lsu_wlast = 1'b1;
    lsu_bready = 1'b1;
    m_arready = 1'b0; m_rdata = 32'h0000_0413; m_rresp = 2'b01; m_rvalid = 1'b0;
    m_rlast = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b10; m_bvalid = 1'b0;
  endtask

  // One cycle of stimulus and the outputs required while it is applied.
  typedef struct packed {
    logic [9:0] in;   // ifu_arv lsu_arv lsu_awv lsu_wv m_arr m_rv m_rl m_awr m_wr m_bv
    logic [7:0] exp;  // m_arv ifu_arr lsu_arr ifu_rv lsu_rv m_awv m_wv lsu_bv
  } vec_t;

  vec_t vecs [28];

  // Reference model state for the random phase: who owns the port and which
  // handshakes of that ownership have already happened downstream.
  int          owner;  // 0 none, 1 IFU read, 2 LSU read, 3 LSU write
  bit          ar_seen, aw_seen, w_seen;
  int unsigned mod_ifu, mod_lsu, mod_wait;

  initial begin
    logic [7:0]  act8;
    logic [11:0] exp12, act12;
    logic [13:0] rbits;
    bit          e_mav, e_rready, e_maw, e_mw, lsu_req;

    // IFU-only read, rdata two cycles after AR
    vecs[0]  = {10'b1_0_0_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[1]  = {10'b1_0_0_0_1_0_0_0_0_0, 8'b1_1_0_0_0_0_0_0};
    vecs[2]  = {10'b0_0_0_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[3]  = {10'b0_0_0_0_0_1_1_0_0_0, 8'b0_0_0_1_0_0_0_0};
    vecs[4]  = {10'b0_0_0_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    // IFU and LSU same cycle: LSU first, second AR blocked, IFU after bubble
    vecs[5]  = {10'b1_1_0_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[6]  = {10'b1_1_0_0_1_0_0_0_0_0, 8'b1_0_1_0_0_0_0_0};
    vecs[7]  = {10'b1_0_0_0_1_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[8]  = {10'b1_0_0_0_0_1_0_0_0_0, 8'b0_0_0_0_1_0_0_0};
    vecs[9]  = {10'b1_0_0_0_0_1_1_0_0_0, 8'b0_0_0_0_1_0_0_0};
    vecs[10] = {10'b1_0_0_0_1_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[11] = {10'b1_0_0_0_1_0_0_0_0_0, 8'b1_1_0_0_0_0_0_0};
    vecs[12] = {10'b0_0_0_0_0_1_1_0_0_0, 8'b0_0_0_1_0_0_0_0};
    vecs[13] = {10'b0_0_0_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    // LSU write, W accepted two cycles before AW
    vecs[14] = {10'b0_0_1_1_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[15] = {10'b0_0_1_1_0_0_0_0_1_0, 8'b0_0_0_0_0_1_1_0};
    vecs[16] = {10'b0_0_1_0_0_0_0_0_1_0, 8'b0_0_0_0_0_1_0_0};
    vecs[17] = {10'b0_0_1_1_0_0_0_1_1_0, 8'b0_0_0_0_0_1_0_0};
    vecs[18] = {10'b0_0_1_0_0_0_0_1_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[19] = {10'b0_0_0_0_0_0_0_0_0_1, 8'b0_0_0_0_0_0_0_1};
    vecs[20] = {10'b0_0_0_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    // LSU read and write together: read first, write after bubble
    vecs[21] = {10'b0_1_1_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[22] = {10'b0_1_1_0_1_0_0_1_0_0, 8'b1_0_1_0_0_0_0_0};
    vecs[23] = {10'b0_0_1_0_0_1_1_0_0_0, 8'b0_0_0_0_1_0_0_0};
    vecs[24] = {10'b0_0_1_1_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};
    vecs[25] = {10'b0_0_1_1_0_0_0_1_1_0, 8'b0_0_0_0_0_1_1_0};
    vecs[26] = {10'b0_0_0_0_0_0_0_0_0_1, 8'b0_0_0_0_0_0_0_1};
    vecs[27] = {10'b0_0_0_0_0_0_0_0_0_0, 8'b0_0_0_0_0_0_0_0};

    // Reset state, with requests present while reset is held
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    #1;
    chk("reset_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                             ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                             lsu_awready, lsu_wready, lsu_bvalid}), 64'd0);
    chk("reset_perf", 64'({perf_ifu_cnt, perf_lsu_cnt} | 64'(perf_wait_cnt)), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    // Table-driven directed scenarios
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, m_arready,
       m_rvalid, m_rlast, m_awready, m_wready, m_bvalid} = vecs[i].in;
      #1;
      act8 = {m_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid,
              m_awvalid, m_wvalid, lsu_bvalid};
      chk($sformatf("vec%0d_hs", i), 64'(act8), 64'(vecs[i].exp));
      if (vecs[i].exp[7])
        chk($sformatf("vec%0d_araddr", i), 64'(m_araddr),
            vecs[i].exp[5] ? 64'h0f00_0004 : 64'h3000_0000);
      if (vecs[i].exp[4]) chk($sformatf("vec%0d_ifu_rd", i), 64'({ifu_rdata, ifu_rresp}), 64'({32'h0000_0413, 2'b01}));
      if (vecs[i].exp[3]) chk($sformatf("vec%0d_lsu_rd", i), 64'({lsu_rdata, lsu_rresp}), 64'({32'h0000_0413, 2'b01}));
      if (vecs[i].exp[2]) chk($sformatf("vec%0d_aw", i), 64'(m_awaddr), 64'h0f00_0008);
      if (vecs[i].exp[1]) chk($sformatf("vec%0d_w", i), 64'({m_wdata, m_wstrb}), 64'({32'hdead_beef, 4'hf}));
      if (vecs[i].exp[0]) chk($sformatf("vec%0d_bresp", i), 64'(lsu_bresp), 64'd2);
    end
    // Table contains 2 IFU grants, 4 LSU grants, IFU blocked 4 cycles
`ifdef ARB_PERF_CNT_EN
    chk("tbl_perf_ifu", 64'(perf_ifu_cnt), 64'd2);
    chk("tbl_perf_lsu", 64'(perf_lsu_cnt), 64'd4);
    chk("tbl_perf_wait", 64'(perf_wait_cnt), 64'd4);
`else
    chk("tbl_perf_ifu", 64'(perf_ifu_cnt), 64'd0);
    chk("tbl_perf_lsu", 64'(perf_lsu_cnt), 64'd0);
    chk("tbl_perf_wait", 64'(perf_wait_cnt), 64'd0);
`endif

    // Reset in the middle of an LSU read, then a normal IFU read
    @(negedge clk);
    clear_inputs();
    lsu_arvalid = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_pre_arvalid", 64'(m_arvalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                               lsu_arready, lsu_rvalid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    lsu_arvalid = 1'b0;
    ifu_arvalid = 1'b1;
    #1;
    chk("post_rst_idle", 64'(m_arvalid), 64'd0);
    @(negedge clk);
    m_arready = 1'b1;
    #1;
    chk("post_rst_ar", 64'({m_arvalid, m_araddr}), 64'({1'b1, 32'h3000_0000}));
    @(negedge clk);
    ifu_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'h0000_0413;
    #1;
    chk("post_rst_rdata", 64'({ifu_rvalid, ifu_rdata}), 64'({1'b1, 32'h0000_0413}));
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; ifu_arvalid = 1'b1;
    #1;
    chk("post_rst_back_idle", 64'(m_arvalid), 64'd0);

    // Randomized traffic against the transaction-level model
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    owner = 0; ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
    mod_ifu = 0; mod_lsu = 0; mod_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rbits = 14'($urandom);
      {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, lsu_wlast, ifu_rready,
       lsu_rready, lsu_bready, m_arready, m_rvalid, m_rlast, m_awready, m_wready,
       m_bvalid} = rbits;
      ifu_araddr = $urandom; lsu_araddr = $urandom; m_rdata = $urandom;
      m_rresp = 2'($urandom); m_bresp = 2'($urandom);
      #1;
      e_mav    = ((owner == 1 && ifu_arvalid) || (owner == 2 && lsu_arvalid)) && !ar_seen;
      e_rready = (owner == 1 && ifu_rready) || (owner == 2 && lsu_rready);
      e_maw    = owner == 3 && lsu_awvalid && !aw_seen;
      e_mw     = owner == 3 && lsu_wvalid && !w_seen;
      exp12 = {e_mav, e_rready, e_maw, e_mw, owner == 3 && lsu_bready,
               owner == 1 && m_arready && !ar_seen, owner == 1 && m_rvalid,
               owner == 2 && m_arready && !ar_seen, owner == 2 && m_rvalid,
               owner == 3 && m_awready && !aw_seen, owner == 3 && m_wready && !w_seen,
               owner == 3 && m_bvalid};
      act12 = {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, ifu_arready, ifu_rvalid,
               lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid};
      chk($sformatf("rnd%0d_hs", c), 64'(act12), 64'(exp12));
      if (e_mav)
        chk($sformatf("rnd%0d_araddr", c), 64'(m_araddr), 64'(owner == 1 ? ifu_araddr : lsu_araddr));
      if (owner == 1 && m_rvalid)
        chk($sformatf("rnd%0d_ifu_r", c), 64'({ifu_rdata, ifu_rresp}), 64'({m_rdata, m_rresp}));
      if (owner == 2 && m_rvalid)
        chk($sformatf("rnd%0d_lsu_r", c), 64'({lsu_rdata, lsu_rresp}), 64'({m_rdata, m_rresp}));
      if (owner == 3 && m_bvalid)
        chk($sformatf("rnd%0d_bresp", c), 64'(lsu_bresp), 64'(m_bresp));

      // Waiting: a requester holds valid while the other one owns the port.
      lsu_req = lsu_arvalid || lsu_awvalid;
      if ((ifu_arvalid && (owner == 2 || owner == 3)) || (lsu_req && owner == 1))
        mod_wait++;
      // Ownership change at the coming clock edge.
      if (owner == 0) begin
        ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
        if (lsu_req && (LSU_FIRST != 0 || !ifu_arvalid)) begin
          owner = lsu_arvalid ? 2 : 3;
          mod_lsu++;
        end else if (ifu_arvalid) begin
          owner = 1;
          mod_ifu++;
        end
      end else if (owner == 3) begin
        if (e_maw && m_awready) aw_seen = 1'b1;
        if (e_mw && m_wready && lsu_wlast) w_seen = 1'b1;
        if (m_bvalid && lsu_bready) owner = 0;
      end else begin
        if (e_mav && m_arready) ar_seen = 1'b1;
        if (m_rvalid && e_rready && m_rlast) owner = 0;
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
`ifdef ARB_PERF_CNT_EN
    chk("rnd_perf_ifu", 64'(perf_ifu_cnt), 64'(mod_ifu));
    chk("rnd_perf_lsu", 64'(perf_lsu_cnt), 64'(mod_lsu));
    chk("rnd_perf_wait", 64'(perf_wait_cnt), 64'(mod_wait));
`else
    chk("rnd_perf_off", 64'({perf_ifu_cnt, perf_lsu_cnt} | 64'(perf_wait_cnt)), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
